// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_fsm
// Description : Main control FSM of the RV32I multicycle core. Sequences
//               fetch / decode / execute / memory / writeback, drives the PC,
//               IR, regfile and memory enables and the datapath mux selects,
//               stalls on the memory ready handshake and flags memory waits
//               that run too long.
//
// Ports       : clk, rst            clock, synchronous active-high reset
//               opcode, funct3      instruction fields from the IR
//               zero, lt, ltu       ALU flags for branch resolution
//               mem_ready           memory completes the current access
//               pc_write, ir_write, reg_write, mem_write, mem_read
//                                   enables (write enables forced 0 in rst)
//               adr_src, result_src, alu_src_a, alu_src_b, alu_op
//                                   datapath mux selects / ALU op class
//               mem_timeout         sticky memory-wait watchdog flag
//               illegal_instr       high while parked in TRAP
//               state_dbg           current state encoding
//
// Options     : ILLEGAL_TRAP_EN - when defined, an illegal opcode parks the
//               FSM in TRAP until reset; otherwise it retires as a NOP.
//
// Revision    : 1.0 - initial release
// ============================================================================
module mc_control_fsm #(
    parameter int WAIT_W       = 8,
    parameter int MEM_WAIT_MAX = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       mem_timeout,
    output logic       illegal_instr,
    output logic [3:0] state_dbg
);

    localparam logic [3:0] c_ST_FETCH    = 4'd0;
    localparam logic [3:0] c_ST_DECODE   = 4'd1;
    localparam logic [3:0] c_ST_MEMADR   = 4'd2;
    localparam logic [3:0] c_ST_MEMREAD  = 4'd3;
    localparam logic [3:0] c_ST_MEMWB    = 4'd4;
    localparam logic [3:0] c_ST_MEMWRITE = 4'd5;
    localparam logic [3:0] c_ST_EXECR    = 4'd6;
    localparam logic [3:0] c_ST_EXECI    = 4'd7;
    localparam logic [3:0] c_ST_ALUWB    = 4'd8;
    localparam logic [3:0] c_ST_JAL      = 4'd9;
    localparam logic [3:0] c_ST_JALR     = 4'd10;
    localparam logic [3:0] c_ST_BRANCH   = 4'd11;
    localparam logic [3:0] c_ST_LUI      = 4'd12;
`ifdef ILLEGAL_TRAP_EN
    localparam logic [3:0] c_ST_TRAP     = 4'd13;
`endif

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;

    localparam logic [WAIT_W-1:0] c_WAIT_ONE = WAIT_W'(1);

    logic [3:0]        r_state;
    logic [3:0]        w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_cnt_nxt;
    logic              r_mem_timeout;
    logic              w_waiting;
    logic              w_taken;
    logic              w_pc_write;
    logic              w_ir_write;
    logic              w_reg_write;
    logic              w_mem_write;

    // ------------------------------------------------------------------------
    // State and wait-counter registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_FETCH;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // A memory wait is any cycle spent in a handshaking state without ready.
    // Leaving such a state always requires mem_ready, so clearing whenever we
    // are not waiting also covers "cleared on state exit".
    assign w_waiting = ((r_state == c_ST_FETCH)   ||
                        (r_state == c_ST_MEMREAD) ||
                        (r_state == c_ST_MEMWRITE)) && !mem_ready;

    always_comb begin
        w_wait_cnt_nxt = '0;
        if (w_waiting) begin
            w_wait_cnt_nxt = (&r_wait_cnt) ? r_wait_cnt : r_wait_cnt + c_WAIT_ONE;
        end
    end

    // Watchdog: sets on the edge the counter reaches the limit, so the flag
    // is visible exactly MEM_WAIT_MAX wait cycles after the stall began.
    // A limit the saturating counter can never reach leaves it disabled.
    generate
        if ((MEM_WAIT_MAX != 0) && ((MEM_WAIT_MAX >> WAIT_W) == 0)) begin : g_wdog
            localparam logic [WAIT_W-1:0] c_WAIT_MAX = WAIT_W'(MEM_WAIT_MAX);
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_mem_timeout <= 1'b0;
                end else if (w_wait_cnt_nxt == c_WAIT_MAX) begin
                    r_mem_timeout <= 1'b1;
                end
            end
        end else begin : g_no_wdog
            always_ff @(posedge clk) begin
                r_mem_timeout <= 1'b0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Branch resolution; funct3 010/011 are not branches and never taken
    // ------------------------------------------------------------------------
    always_comb begin
        w_taken = 1'b0;
        case (funct3)
            3'b000:  w_taken = zero;
            3'b001:  w_taken = !zero;
            3'b100:  w_taken = lt;
            3'b101:  w_taken = !lt;
            3'b110:  w_taken = ltu;
            3'b111:  w_taken = !ltu;
            default: w_taken = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Next state and Moore outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_write  = 1'b0;
        mem_read     = 1'b0;
        adr_src      = 1'b0;
        result_src   = 2'b00;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        alu_op       = 2'b00;

        case (r_state)
            c_ST_FETCH: begin
                // PC+4 goes straight from the ALU into the PC
                mem_read   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    w_ir_write  = 1'b1;
                    w_pc_write  = 1'b1;
                    w_state_nxt = c_ST_DECODE;
                end
            end
            c_ST_DECODE: begin
                // Speculatively compute OldPC+imm for branch/jal targets
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    c_OP_LOAD, c_OP_STORE: w_state_nxt = c_ST_MEMADR;
                    c_OP_RTYPE:            w_state_nxt = c_ST_EXECR;
                    c_OP_ITYPE:            w_state_nxt = c_ST_EXECI;
                    c_OP_JAL:              w_state_nxt = c_ST_JAL;
                    c_OP_JALR:             w_state_nxt = c_ST_JALR;
                    c_OP_BRANCH:           w_state_nxt = c_ST_BRANCH;
                    c_OP_LUI:              w_state_nxt = c_ST_LUI;
`ifdef ILLEGAL_TRAP_EN
                    default:               w_state_nxt = c_ST_TRAP;
`else
                    // PC already advanced in FETCH, so this retires as a NOP
                    default:               w_state_nxt = c_ST_FETCH;
`endif
                endcase
            end
            c_ST_MEMADR: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                w_state_nxt = (opcode == c_OP_LOAD) ? c_ST_MEMREAD : c_ST_MEMWRITE;
            end
            c_ST_MEMREAD: begin
                mem_read = 1'b1;
                adr_src  = 1'b1;
                if (mem_ready) begin
                    w_state_nxt = c_ST_MEMWB;
                end
            end
            c_ST_MEMWB: begin
                result_src  = 2'b01;
                w_reg_write = 1'b1;
                w_state_nxt = c_ST_FETCH;
            end
            c_ST_MEMWRITE: begin
                w_mem_write = 1'b1;
                adr_src     = 1'b1;
                if (mem_ready) begin
                    w_state_nxt = c_ST_FETCH;
                end
            end
            c_ST_EXECR: begin
                alu_src_a   = 2'b10;
                alu_op      = 2'b10;
                w_state_nxt = c_ST_ALUWB;
            end
            c_ST_EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_op      = 2'b10;
                w_state_nxt = c_ST_ALUWB;
            end
            c_ST_ALUWB: begin
                w_reg_write = 1'b1;
                w_state_nxt = c_ST_FETCH;
            end
            c_ST_JAL: begin
                // PC <- target held in ALUOut; ALU computes the link OldPC+4
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b10;
                w_pc_write  = 1'b1;
                w_state_nxt = c_ST_ALUWB;
            end
            c_ST_JALR: begin
                // Overwrite ALUOut with rs1+imm, then reuse the JAL path
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                w_state_nxt = c_ST_JAL;
            end
            c_ST_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_op      = 2'b01;
                w_pc_write  = w_taken;
                w_state_nxt = c_ST_FETCH;
            end
            c_ST_LUI: begin
                alu_src_a   = 2'b11;
                alu_src_b   = 2'b01;
                w_state_nxt = c_ST_ALUWB;
            end
`ifdef ILLEGAL_TRAP_EN
            c_ST_TRAP: begin
                w_state_nxt = c_ST_TRAP;
            end
`endif
            default: begin
                w_state_nxt = c_ST_FETCH;
            end
        endcase
    end

    // Reset in flight must not leave a partial write behind
    assign pc_write    = w_pc_write  && !rst;
    assign ir_write    = w_ir_write  && !rst;
    assign reg_write   = w_reg_write && !rst;
    assign mem_write   = w_mem_write && !rst;
    assign mem_timeout = r_mem_timeout;
    assign state_dbg   = r_state;

`ifdef ILLEGAL_TRAP_EN
    assign illegal_instr = (r_state == c_ST_TRAP);
`else
    assign illegal_instr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_control_fsm
// Description : Self-checking bench for mc_control_fsm. Directed scenarios
//               plus a randomized instruction stream checked against an
//               instruction-level reference model (expected state path per
//               opcode class, wait handshakes and watchdog run-length).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_control_fsm;

    localparam int WAIT_W  = 8;
    localparam int WAIT_MX = 4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero, lt, ltu, mem_ready;
    logic       pc_write, adr_src, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic       mem_timeout, illegal_instr;
    logic [3:0] state_dbg;

    logic [5:0] en;
    logic [7:0] mx;
    assign en = {pc_write, ir_write, reg_write, mem_write, mem_read, adr_src};
    assign mx = {result_src, alu_src_a, alu_src_b, alu_op};

    int total = 0;
    int bad   = 0;

    mc_control_fsm #(.WAIT_W(WAIT_W), .MEM_WAIT_MAX(WAIT_MX)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .mem_timeout(mem_timeout),
        .illegal_instr(illegal_instr), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Mux selects per state, straight from the state table of the design
    function automatic logic [7:0] exp_mux(input logic [3:0] st);
        case (st)
            4'd0:    return {2'b10, 2'b00, 2'b10, 2'b00};
            4'd1:    return {2'b00, 2'b01, 2'b01, 2'b00};
            4'd2:    return {2'b00, 2'b10, 2'b01, 2'b00};
            4'd4:    return {2'b01, 2'b00, 2'b00, 2'b00};
            4'd6:    return {2'b00, 2'b10, 2'b00, 2'b10};
            4'd7:    return {2'b00, 2'b10, 2'b01, 2'b10};
            4'd9:    return {2'b00, 2'b01, 2'b10, 2'b00};
            4'd10:   return {2'b00, 2'b10, 2'b01, 2'b00};
            4'd11:   return {2'b00, 2'b10, 2'b00, 2'b01};
            4'd12:   return {2'b00, 2'b11, 2'b01, 2'b00};
            default: return 8'h00;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1; opcode = OP_ITYPE; funct3 = 3'd0;
        zero = 1'b0; lt = 1'b0; ltu = 1'b0;
        tick();
        @(negedge clk);
        total++;
        if (state_dbg !== 4'd0) begin
            bad++; $display("FAIL reset_state: got %0d exp 0", state_dbg);
        end
        total++;
        if ({pc_write, ir_write, reg_write, mem_write} !== 4'b0000) begin
            bad++; $display("FAIL reset_we_forced: got %b exp 0000",
                            {pc_write, ir_write, reg_write, mem_write});
        end
        tick();
        rst = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (en !== 6'b000010) begin
            bad++; $display("FAIL reset_fetch_en: got %b exp 000010", en);
        end
        total++;
        if (mx !== exp_mux(4'd0)) begin
            bad++; $display("FAIL reset_fetch_mux: got %h exp %h", mx, exp_mux(4'd0));
        end
        total++;
        if ({mem_timeout, illegal_instr} !== 2'b00) begin
            bad++; $display("FAIL reset_flags: got %b exp 00", {mem_timeout, illegal_instr});
        end
    endtask

    task automatic test_addi();
        logic [3:0] st[5];
        logic [5:0] ex[5];
        st = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
        ex = '{6'b110010, 6'b000000, 6'b000000, 6'b001000, 6'b110010};
        do_reset();
        opcode = OP_ITYPE; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (state_dbg !== st[i] || en !== ex[i] || mx !== exp_mux(st[i])) begin
                bad++;
                $display("FAIL addi_cyc%0d: got st=%0d en=%b mx=%h exp st=%0d en=%b mx=%h",
                         i, state_dbg, en, mx, st[i], ex[i], exp_mux(st[i]));
            end
            tick();
        end
    endtask

    task automatic test_lw_wait();
        logic [3:0] st[9];
        logic [5:0] ex[9];
        logic       rd[9];
        st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
        ex = '{6'b110010, 6'b0, 6'b0, 6'b000011, 6'b000011, 6'b000011,
               6'b000011, 6'b001000, 6'b000010};
        rd = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        opcode = OP_LOAD;
        for (int i = 0; i < 9; i++) begin
            mem_ready = rd[i];
            @(negedge clk);
            total++;
            if (state_dbg !== st[i] || en !== ex[i] || mx !== exp_mux(st[i])) begin
                bad++;
                $display("FAIL lw_cyc%0d: got st=%0d en=%b mx=%h exp st=%0d en=%b mx=%h",
                         i, state_dbg, en, mx, st[i], ex[i], exp_mux(st[i]));
            end
            tick();
        end
        total++;
        if (mem_timeout !== 1'b0) begin
            bad++; $display("FAIL lw_no_timeout: got %b exp 0", mem_timeout);
        end
    endtask

    task automatic test_branch();
        logic [2:0] f3[4];
        logic [2:0] fl[4];
        logic       tk[4];
        f3 = '{3'b000, 3'b000, 3'b110, 3'b010};
        fl = '{3'b100, 3'b000, 3'b001, 3'b111};
        tk = '{1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        opcode = OP_BRANCH; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            funct3 = f3[i];
            {zero, lt, ltu} = fl[i];
            tick();
            tick();
            @(negedge clk);
            total++;
            if (state_dbg !== 4'd11 || pc_write !== tk[i] || mx !== exp_mux(4'd11)) begin
                bad++;
                $display("FAIL branch_%0d: got st=%0d pcw=%b mx=%h exp st=11 pcw=%b mx=%h",
                         i, state_dbg, pc_write, mx, tk[i], exp_mux(4'd11));
            end
            tick();
        end
    endtask

    task automatic test_jalr();
        logic [3:0] st[6];
        logic [5:0] ex[6];
        st = '{4'd0, 4'd1, 4'd10, 4'd9, 4'd8, 4'd0};
        ex = '{6'b110010, 6'b0, 6'b0, 6'b100000, 6'b001000, 6'b110010};
        do_reset();
        opcode = OP_JALR; mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if (state_dbg !== st[i] || en !== ex[i] || mx !== exp_mux(st[i])) begin
                bad++;
                $display("FAIL jalr_cyc%0d: got st=%0d en=%b mx=%h exp st=%0d en=%b mx=%h",
                         i, state_dbg, en, mx, st[i], ex[i], exp_mux(st[i]));
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        do_reset();
        opcode = OP_ITYPE; mem_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            total++;
            if (mem_timeout !== (i >= WAIT_MX) || state_dbg !== 4'd0) begin
                bad++;
                $display("FAIL timeout_wait%0d: got to=%b st=%0d exp to=%b st=0",
                         i, mem_timeout, state_dbg, (i >= WAIT_MX));
            end
            tick();
        end
        mem_ready = 1'b1;
        tick();
        @(negedge clk);
        total++;
        if (mem_timeout !== 1'b1 || state_dbg !== 4'd1) begin
            bad++; $display("FAIL timeout_sticky: got to=%b st=%0d exp to=1 st=1",
                            mem_timeout, state_dbg);
        end
        do_reset();
        @(negedge clk);
        total++;
        if (mem_timeout !== 1'b0) begin
            bad++; $display("FAIL timeout_cleared: got %b exp 0", mem_timeout);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        opcode = OP_BAD; mem_ready = 1'b1;
        tick();
        tick();
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (state_dbg !== 4'd13 || illegal_instr !== 1'b1 || en !== 6'b0) begin
                bad++;
                $display("FAIL trap_hold%0d: got st=%0d ill=%b en=%b exp st=13 ill=1 en=0",
                         i, state_dbg, illegal_instr, en);
            end
            tick();
        end
        do_reset();
`endif
        @(negedge clk);
        total++;
        if (state_dbg !== 4'd0 || illegal_instr !== 1'b0) begin
            bad++; $display("FAIL illegal_to_fetch: got st=%0d ill=%b exp st=0 ill=0",
                            state_dbg, illegal_instr);
        end
    endtask

    task automatic test_rst_memwrite();
        do_reset();
        opcode = OP_STORE; mem_ready = 1'b1;
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (state_dbg !== 4'd5 || mem_write !== 1'b1 || adr_src !== 1'b1) begin
            bad++; $display("FAIL sw_memwrite: got st=%0d mw=%b adr=%b exp st=5 mw=1 adr=1",
                            state_dbg, mem_write, adr_src);
        end
        tick();
        rst = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        total++;
        if (mem_write !== 1'b0) begin
            bad++; $display("FAIL sw_rst_forced: got mw=%b exp 0", mem_write);
        end
        tick();
        rst = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (state_dbg !== 4'd0 || mem_write !== 1'b0) begin
            bad++; $display("FAIL sw_rst_abort: got st=%0d mw=%b exp st=0 mw=0",
                            state_dbg, mem_write);
        end
    endtask

    // Random instruction stream. The model knows, per opcode class, the list
    // of states the instruction walks through; handshake states repeat while
    // mem_ready is low, and the watchdog trips after WAIT_MX consecutive waits.
    task automatic test_random();
        logic [6:0] ops[12];
        logic [3:0] path[$];
        logic [3:0] st;
        logic [5:0] ex;
        logic       rdy, stay, tkn, hs;
        logic       exp_to;
        int         run, waits, nops;
        ops = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_JALR,
                OP_BRANCH, OP_LUI, OP_BAD, 7'b0010111, 7'b1110011, 7'b0001111};
`ifdef ILLEGAL_TRAP_EN
        nops = 8;
`else
        nops = 12;
`endif
        do_reset();
        exp_to = 1'b0;
        run = 0;
        repeat (150) begin
            opcode = ops[$urandom_range(0, nops - 1)];
            funct3 = 3'($urandom_range(0, 7));
            path = '{4'd0, 4'd1};
            case (opcode)
                OP_LOAD:   begin path.push_back(4'd2); path.push_back(4'd3); path.push_back(4'd4); end
                OP_STORE:  begin path.push_back(4'd2); path.push_back(4'd5); end
                OP_RTYPE:  begin path.push_back(4'd6); path.push_back(4'd8); end
                OP_ITYPE:  begin path.push_back(4'd7); path.push_back(4'd8); end
                OP_JAL:    begin path.push_back(4'd9); path.push_back(4'd8); end
                OP_JALR:   begin path.push_back(4'd10); path.push_back(4'd9); path.push_back(4'd8); end
                OP_BRANCH: path.push_back(4'd11);
                OP_LUI:    begin path.push_back(4'd12); path.push_back(4'd8); end
                default:   ;
            endcase
            foreach (path[k]) begin
                st = path[k];
                hs = (st == 4'd0) || (st == 4'd3) || (st == 4'd5);
                waits = 0;
                stay = 1'b1;
                while (stay) begin
                    rdy = (waits >= 6) ? 1'b1 : ($urandom_range(0, 3) != 0);
                    mem_ready = rdy;
                    {zero, lt, ltu} = 3'($urandom_range(0, 7));
                    case (funct3)
                        3'b000:  tkn = zero;
                        3'b001:  tkn = !zero;
                        3'b100:  tkn = lt;
                        3'b101:  tkn = !lt;
                        3'b110:  tkn = ltu;
                        3'b111:  tkn = !ltu;
                        default: tkn = 1'b0;
                    endcase
                    ex = {(st == 4'd0 && rdy) || st == 4'd9 || (st == 4'd11 && tkn),
                          st == 4'd0 && rdy,
                          st == 4'd4 || st == 4'd8,
                          st == 4'd5,
                          st == 4'd0 || st == 4'd3,
                          st == 4'd3 || st == 4'd5};
                    @(negedge clk);
                    total++;
                    if (state_dbg !== st || en !== ex || mx !== exp_mux(st) ||
                        mem_timeout !== exp_to || illegal_instr !== 1'b0) begin
                        bad++;
                        $display("FAIL rnd op=%b: got st=%0d en=%b mx=%h to=%b ill=%b exp st=%0d en=%b mx=%h to=%b ill=0",
                                 opcode, state_dbg, en, mx, mem_timeout, illegal_instr,
                                 st, ex, exp_mux(st), exp_to);
                    end
                    stay = hs && !rdy;
                    if (stay) begin
                        run++;
                        waits++;
                    end else begin
                        run = 0;
                    end
                    if (run >= WAIT_MX) exp_to = 1'b1;
                    tick();
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; opcode = '0; funct3 = '0;
        zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b0;
        test_reset();
        test_addi();
        test_lw_wait();
        test_branch();
        test_jalr();
        test_timeout();
        test_illegal();
        test_rst_memwrite();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
